mem_port_initiator: RTL and testbench
=====================================

# mem_port_initiator

Initiator for the blocking single-outstanding memory port (`maddr`/`mrd`/`mwr`/`mwdata` out, `mresp`/`mrdata` in). It sits between a CPU-side or DMA-side valid/ready command stream and the memory responder.
- Buffers commands in a small FIFO.
- Drives one transaction at a time on the port and holds it until `mresp`.
- Returns each completion on a valid/ready response stream.
- A timeout turns a hung responder into an error response instead of a deadlock.

## Interface
- `CMD_DEPTH`, 2: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 256: cycles in ISSUE without `mresp` before error completion; 0 disables the timeout.
- `clk` in 1: clock, all flops on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: command valid.
- `req_ready` out 1: FIFO not full.
- `req_addr` in 32: byte address; bits [1:0] are passed through unchanged.
- `req_we` in 4: byte write enables; 4'b0000 means read.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: response slot full.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_write` out 1: completed command was a write.
- `rsp_err` out 1: completed by timeout.
- `maddr` out 32: port address.
- `mrd` out 1: port read request.
- `mwr` out 4: port byte write strobes.
- `mwdata` out 32: port write data.
- `mresp` in 1: one-cycle completion pulse.
- `mrdata` in 32: read data, valid in the `mresp` cycle.
- `busy` out 1: FIFO non-empty, or state ISSUE, or `rsp_valid`.
- `stray_resp` out 1: sticky flag; set by any `mresp` seen outside ISSUE; cleared only by reset.

## Operation
- Handshakes:
  - Command accepted on `req_valid & req_ready`.
  - Response consumed on `rsp_valid & rsp_ready`.
  - `rsp_*` payload is stable while `rsp_valid & ~rsp_ready`.
- FSM, 2 states, IDLE/ISSUE:
  - IDLE→ISSUE when the FIFO is non-empty and the slot is free (`~rsp_valid`, or consumed this cycle). The FIFO head loads the issue register (addr/we/wdata) and pops. The timeout counter clears.
  - ISSUE→IDLE when `mresp`=1. The response slot loads `{rdata = we==0 ? mrdata : 0, write = |we, err = 0}`.
  - ISSUE→IDLE when the counter reaches `TIMEOUT` with no `mresp`. The slot loads `{0, |we, 1}` and the command is dropped.
  - If `mresp` and the timeout coincide, `mresp` wins and `err` = 0.
- Port drive:
  - `maddr`/`mwdata` come from the issue register; they are 0 in IDLE.
  - `mrd = ISSUE & (we==0) & ~mresp`.
  - `mwr = (ISSUE & ~mresp) ? we : 0`.
  - The `~mresp` gating is the only combinational input→output path. It guarantees the request is withdrawn in the completion cycle, so the responder never sees a duplicate request.
  - Address and data are held stable for the whole ISSUE period.
- `mresp` outside ISSUE: discarded, `stray_resp` set, no response generated. This covers a late response after a timeout.
- Reset mid-operation: the FIFO, issue register and slot are all discarded.
- Arithmetic:
  - FIFO pointers are log2(`CMD_DEPTH`)+1 bits with a wrap bit. Full = MSBs differ and LSBs are equal.
  - Timeout counter is $clog2(`TIMEOUT`+1) bits and saturates.

## Timing
- Reset values:
  - `req_ready` 0 while `rst_n`=0, then 1.
  - All other outputs 0; state IDLE.
- Latency, with a zero-wait responder:
  - Command accepted at edge k.
  - Issue register loaded at edge k+1; `mrd`/`mwr` high during cycle k+1..k+2.
  - `mresp` high during k+2..k+3.
  - `rsp_valid` high after edge k+3.
- Throughput: one transaction per 3 cycles with zero wait and `rsp_ready` held at 1. Each responder wait state adds one cycle.
- FIFO full: `req_ready`=0. A push and a pop in the same cycle while full is not allowed, because ready is low.
- FIFO empty with a command arriving: no bypass. Issue happens at earliest the next edge.

## Structure
- Package `mem_port_pkg`:
  - `mem_cmd_t` {addr[31:0], we[3:0], wdata[31:0]}.
  - `mem_rsp_t` {rdata[31:0], write, err}.
  - `mip_state_e` {IDLE, ISSUE}.
- Sub-module `mem_cmd_fifo`: parameterized synchronous FIFO of `mem_cmd_t` with asynchronous active-low reset, push/pop, and full/empty outputs.
- FSM, issue register, response slot and timeout counter live in the top module.

## Test plan
- Read, zero-wait responder, memory[0x100]=0xDEADBEEF: push read 0x100 → `mrd`=1 for exactly 1 cycle, `rsp_valid` 3 cycles after accept, `rsp_rdata`=0xDEADBEEF, `rsp_write`=0, `rsp_err`=0.
- Byte write: `we`=4'b0101, `wdata`=0x11223344 to 0x200 holding 0xAAAAAAAA, then a read of 0x200 → 0xAA22AA44; `mwr` is 0 in the `mresp` cycle.
- Backpressure: 3 commands pushed back-to-back with `CMD_DEPTH`=2 → `req_ready`=0 on the third until the first pop. With `rsp_ready`=0 held for 10 cycles, no second issue occurs and the slot payload stays stable.
- Timeout: `TIMEOUT`=8, responder never answers → `mrd` high 8 cycles, then `rsp_err`=1 with `rsp_rdata`=0. An injected `mresp` 2 cycles later sets `stray_resp`=1 and produces no response.
- Random stall: responder stalls up to 5 cycles, 200 random reads/writes against a scoreboard → all data matches and responses arrive in order.
- Reset: assert `rst_n` low while in ISSUE → all outputs drop to 0 immediately (asynchronous). After release, `req_ready`=1 and `busy`=0.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types for the memory-port initiator: command/response payloads and FSM states.
package mem_port_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        write;
    logic        err;
  } mem_rsp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } mip_state_e;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO; pointers carry a wrap bit so full/empty need no extra counter.
module mem_cmd_fifo
  import mem_port_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  mem_cmd_t wdata_i,
  input  logic     pop_i,
  output mem_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  mem_cmd_t    mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage holds only payload, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mem_port_initiator.sv
// Single-outstanding memory-port initiator: command FIFO in, one port transaction at a time,
// completions out through a one-entry response slot, with a timeout against a hung responder.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 2,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] maddr,
  output logic        mrd,
  output logic [3:0]  mwr,
  output logic [31:0] mwdata,
  input  logic        mresp,
  input  logic [31:0] mrdata,
  output logic        busy,
  output logic        stray_resp
);

  localparam int unsigned      CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mip_state_e       state_q;
  mem_cmd_t         cmd_q, head;
  mem_rsp_t         rsp_q;
  logic             rsp_valid_q, stray_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full, fifo_empty, push, pop, slot_free, timeout_hit, in_issue;

  assign in_issue    = (state_q == ISSUE);
  assign req_ready   = rst_n & ~fifo_full;
  assign push        = req_valid & req_ready;
  assign slot_free   = ~rsp_valid_q | rsp_ready;
  assign pop         = ~in_issue & ~fifo_empty & slot_free;
  assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_MAX);

  mem_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ('{addr: req_addr, we: req_we, wdata: req_wdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
      stray_q     <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      if (mresp && !in_issue) stray_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            cmd_q   <= head;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_d;
          // A response in the same cycle as the timeout still counts as a good completion.
          if (mresp) begin
            rsp_q       <= '{rdata: (cmd_q.we == 4'b0000) ? mrdata : 32'h0,
                             write: |cmd_q.we, err: 1'b0};
            rsp_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            rsp_q       <= '{rdata: 32'h0, write: |cmd_q.we, err: 1'b1};
            rsp_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request strobes drop combinationally in the completion cycle so the responder never sees a repeat.
  assign maddr  = in_issue ? cmd_q.addr : 32'h0;
  assign mwdata = in_issue ? cmd_q.wdata : 32'h0;
  assign mrd    = in_issue & (cmd_q.we == 4'b0000) & ~mresp;
  assign mwr    = (in_issue & ~mresp) ? cmd_q.we : 4'b0000;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_q.rdata;
  assign rsp_write  = rsp_q.write;
  assign rsp_err    = rsp_q.err;
  assign busy       = ~fifo_empty | in_issue | rsp_valid_q;
  assign stray_resp = stray_q;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed and scoreboarded bench for mem_port_initiator with a behavioural memory responder.
module tb_mem_port_initiator;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_we;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] maddr, mwdata, mrdata;
  logic        mrd, mresp, busy, stray_resp;
  logic [3:0]  mwr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_initiator #(.CMD_DEPTH(2), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_write  (rsp_write),
    .rsp_err    (rsp_err),
    .maddr      (maddr),
    .mrd        (mrd),
    .mwr        (mwr),
    .mwdata     (mwdata),
    .mresp      (mresp),
    .mrdata     (mrdata),
    .busy       (busy),
    .stray_resp (stray_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: answers a pending request after stall_tgt wait cycles; force_pulse injects a raw mresp.
  logic        resp_en, force_pulse, rand_stall;
  logic [31:0] rmem [0:255];
  int unsigned stall_tgt, wait_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mresp     <= 1'b0;
      mrdata    <= 32'h0;
      wait_cnt  <= 0;
      stall_tgt <= 0;
      for (int i = 0; i < 256; i++) rmem[i] <= 32'hA5A50000 | i;
      rmem[64]  <= 32'hDEADBEEF;
      rmem[128] <= 32'hAAAAAAAA;
    end else begin
      mresp  <= force_pulse;
      mrdata <= 32'h0;
      if (resp_en && !mresp && (mrd || mwr != 4'b0000)) begin
        if (wait_cnt >= stall_tgt) begin
          mresp    <= 1'b1;
          wait_cnt <= 0;
          if (mrd) mrdata <= rmem[maddr[9:2]];
          for (int b = 0; b < 4; b++)
            if (mwr[b]) rmem[maddr[9:2]][8*b +: 8] <= mwdata[8*b +: 8];
          if (rand_stall) stall_tgt <= $urandom_range(0, 5);
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = d;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("push_wait", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] rd, output logic wr, output logic er);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) chk("rsp_wait", 0, 1);
    rd = rsp_rdata; wr = rsp_write; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [31:0] rd, ref_mem [0:15];
  logic        wr, er;
  logic [33:0] exp_q [$];
  logic [33:0] e;
  int          cnt;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0;
    rsp_ready = 1'b0; resp_en = 1'b1; force_pulse = 1'b0; rand_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mrd", mrd, 0);
    chk("rst_maddr", maddr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // Zero-wait read of 0x100
    push(32'h100, 4'b0000, 32'h0);
    @(negedge clk);
    chk("rd_c0_mrd", mrd, 0);
    chk("rd_c0_busy", busy, 1);
    @(negedge clk);
    chk("rd_c1_mrd", mrd, 1);
    chk("rd_c1_maddr", maddr, 32'h100);
    @(negedge clk);
    chk("rd_c2_mrd", mrd, 0);
    chk("rd_c2_mresp", mresp, 1);
    chk("rd_c2_valid", rsp_valid, 0);
    @(negedge clk);
    chk("rd_c3_valid", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_write", rsp_write, 0);
    chk("rd_err", rsp_err, 0);
    chk("rd_stray", stray_resp, 0);
    consume();

    // Byte write then read-back of 0x200
    push(32'h200, 4'b0101, 32'h11223344);
    @(negedge clk);
    @(negedge clk);
    chk("wr_c1_mwr", mwr, 4'b0101);
    chk("wr_c1_mwdata", mwdata, 32'h11223344);
    chk("wr_c1_mrd", mrd, 0);
    @(negedge clk);
    chk("wr_c2_mresp", mresp, 1);
    chk("wr_c2_mwr", mwr, 0);
    @(negedge clk);
    chk("wr_valid", rsp_valid, 1);
    chk("wr_write", rsp_write, 1);
    chk("wr_rdata", rsp_rdata, 0);
    consume();
    push(32'h200, 4'b0000, 32'h0);
    get_rsp(rd, wr, er);
    chk("wr_readback", rd, 32'hAA22AA44);

    // Backpressure: hold the slot full, fill the FIFO, present a third command
    push(32'h100, 4'b0000, 32'h0);
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_slot_full", rsp_valid, 1);
    push(32'h300, 4'b1111, 32'h12345678);
    push(32'h300, 4'b0000, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h100; req_we = 4'b0000; req_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready_low", req_ready, 0);
      chk("bp_no_issue", {mrd, mwr}, 0);
      chk("bp_slot_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_slot_valid", rsp_valid, 1);
      @(negedge clk);
    end
    consume();
    @(negedge clk);
    chk("bp_ready_after_pop", req_ready, 1);
    chk("bp_issue_a", mwr, 4'b1111);
    @(posedge clk);
    #1 req_valid = 1'b0;
    get_rsp(rd, wr, er);
    chk("bp_a", {er, wr, rd}, {1'b0, 1'b1, 32'h0});
    get_rsp(rd, wr, er);
    chk("bp_b", {er, wr, rd}, {1'b0, 1'b0, 32'h12345678});
    get_rsp(rd, wr, er);
    chk("bp_c", {er, wr, rd}, {1'b0, 1'b0, 32'hDEADBEEF});

    // Timeout with a silent responder, then a late stray response
    resp_en = 1'b0;
    push(32'h100, 4'b0000, 32'h0);
    cnt = 0;
    for (int i = 0; i < 30 && !rsp_valid; i++) begin
      @(negedge clk);
      if (mrd) cnt++;
    end
    chk("to_mrd_cycles", cnt, 8);
    chk("to_valid", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_write", rsp_write, 0);
    consume();
    chk("to_stray_before", stray_resp, 0);
    @(negedge clk);
    force_pulse = 1'b1;
    @(posedge clk);
    #1 force_pulse = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("to_stray_set", stray_resp, 1);
    chk("to_stray_no_rsp", rsp_valid, 0);
    chk("to_stray_busy", busy, 0);
    resp_en = 1'b1;

    // Random stalls against a scoreboard
    rand_stall = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A50000 | (208 + i);
    fork
      begin
        int unsigned j;
        logic [3:0]  we;
        logic [31:0] d;
        for (int i = 0; i < 200; i++) begin
          j  = $urandom_range(0, 15);
          we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
          d  = $urandom;
          if (we == 4'b0000) begin
            exp_q.push_back({1'b0, 1'b0, ref_mem[j]});
          end else begin
            for (int b = 0; b < 4; b++)
              if (we[b]) ref_mem[j][8*b +: 8] = d[8*b +: 8];
            exp_q.push_back({1'b0, 1'b1, 32'h0});
          end
          push(32'h340 + (j << 2), we, d);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          get_rsp(rd, wr, er);
          if (exp_q.size() == 0) begin
            chk("rand_sb_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rand_rsp", {er, wr, rd}, e);
          end
        end
      end
    join
    rand_stall = 1'b0;

    // Asynchronous reset while a transaction is outstanding and another is queued
    resp_en = 1'b0;
    push(32'h100, 4'b0000, 32'h0);
    push(32'h104, 4'b0000, 32'h0);
    @(negedge clk);
    chk("rst_pre_mrd", mrd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mrd", mrd, 0);
    chk("arst_maddr", maddr, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_stray", stray_resp, 0);
    chk("arst_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", req_ready, 1);
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_mrd", mrd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
